// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard command/response codes and the controller state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_RESET    = 8'hFF;
  localparam logic [7:0] PS2_SET_LED  = 8'hED;
  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;

  typedef enum logic [2:0] {
    INIT_SEND = 3'd0,
    TX_WAIT   = 3'd1,
    RESP_WAIT = 3'd2,
    BAT_WAIT  = 3'd3,
    IDLE      = 3'd4,
    LED_SEND  = 3'd5,
    LED_DATA  = 3'd6,
    ERR       = 3'd7
  } ps2_state_t;

  // A resend re-enters the send state that originally produced the byte.
  function automatic ps2_state_t send_state_of(input logic [7:0] b);
    case (b)
      PS2_RESET:   return INIT_SEND;
      PS2_SET_LED: return LED_SEND;
      default:     return LED_DATA;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through byte FIFO; a push when full is dropped and flagged.
module ps2_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic             overflow
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             overflow_reg;
  logic             do_push, do_pop;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == FULL_COUNT);
  assign do_pop    = pop && !empty;
  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign do_push   = push && (!full || do_pop);
  assign head_data = empty ? '0 : mem[rd_ptr_reg];
  assign overflow  = overflow_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (push && !do_push) overflow_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard command sequencer: reset/BAT bring-up, LED writes with
// ACK/resend/timeout retry, and a scan-code FIFO for unsolicited bytes.
module ps2_kbd_ctrl #(
  parameter int TIMEOUT_CYCLES     = 1_000_000,
  parameter int BAT_TIMEOUT_CYCLES = 50_000_000,
  parameter int MAX_RETRY          = 3,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] tx_data,
  output logic       tx_req,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic [2:0] led_state,
  input  logic       led_update,
  output logic [7:0] scan_data,
  output logic       scan_valid,
  input  logic       scan_pop,
  output logic       init_done,
  output logic       busy,
  output logic       error,
  output logic       overflow
);
  import ps2_pkg::*;

  localparam int TMAX = (BAT_TIMEOUT_CYCLES > TIMEOUT_CYCLES) ? BAT_TIMEOUT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] BAT_LOAD = TW'(BAT_TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    RETRY_LIMIT = 8'(MAX_RETRY);

  ps2_state_t    state_reg, state_next;
  logic [7:0]    cur_byte_reg, cur_byte_next;
  logic [7:0]    retry_reg, retry_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [2:0]    led_latched_reg, led_latched_next;
  logic          led_pending_reg, led_pending_next;
  logic          init_done_reg, init_done_next;
  logic          error_reg, error_next;
  logic          busy_reg, busy_next;
  logic          tx_req_reg, tx_req_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic          fifo_push, fifo_empty, fifo_full_unused;
  logic          resend;

  always_comb begin
    state_next       = state_reg;
    cur_byte_next    = cur_byte_reg;
    retry_next       = retry_reg;
    timer_next       = (timer_reg == '0) ? '0 : timer_reg - 1'b1;
    led_latched_next = led_latched_reg;
    led_pending_next = led_pending_reg;
    init_done_next   = init_done_reg;
    error_next       = error_reg;
    tx_req_next      = 1'b0;
    tx_data_next     = tx_data_reg;
    fifo_push        = rx_ready;
    resend           = 1'b0;

    // Requests arriving mid-sequence are remembered (latest value wins).
    if (led_update && state_reg != IDLE && state_reg != ERR) begin
      led_latched_next = led_state;
      led_pending_next = 1'b1;
    end

    case (state_reg)
      INIT_SEND, LED_SEND, LED_DATA: begin
        tx_req_next  = 1'b1;
        tx_data_next = cur_byte_reg;
        timer_next   = TO_LOAD;
        state_next   = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_ready) begin
          timer_next = TO_LOAD;
          state_next = RESP_WAIT;
        end else if (timer_reg == '0) begin
          resend = 1'b1;
        end
      end
      RESP_WAIT: begin
        if (rx_ready && rx_data == PS2_ACK) begin
          fifo_push  = 1'b0;
          retry_next = '0;
          if (cur_byte_reg == PS2_RESET) begin
            timer_next = BAT_LOAD;
            state_next = BAT_WAIT;
          end else if (cur_byte_reg == PS2_SET_LED) begin
            cur_byte_next = {5'b0, led_latched_reg};
            state_next    = LED_DATA;
          end else begin
            state_next = IDLE;
          end
        end else if (rx_ready && rx_data == PS2_RESEND) begin
          fifo_push = 1'b0;
          resend    = 1'b1;
        end else if (timer_reg == '0) begin
          resend = 1'b1;
        end
      end
      BAT_WAIT: begin
        if (rx_ready && rx_data == PS2_BAT_OK) begin
          fifo_push      = 1'b0;
          init_done_next = 1'b1;
          state_next     = IDLE;
        end else if (rx_ready && rx_data == PS2_BAT_FAIL) begin
          fifo_push  = 1'b0;
          state_next = ERR;
        end else if (timer_reg == '0) begin
          state_next = ERR;
        end
      end
      IDLE: begin
        if (led_update || led_pending_reg) begin
          if (led_update) led_latched_next = led_state;
          led_pending_next = 1'b0;
          cur_byte_next    = PS2_SET_LED;
          retry_next       = '0;
          state_next       = LED_SEND;
        end
      end
      ERR:     state_next = ERR;
      default: state_next = INIT_SEND;
    endcase

    if (resend) begin
      if (retry_reg < RETRY_LIMIT) begin
        retry_next = retry_reg + 1'b1;
        state_next = send_state_of(cur_byte_reg);
      end else begin
        state_next = ERR;
      end
    end

    if (state_next == ERR) error_next = 1'b1;
    busy_next = !(state_next == IDLE || state_next == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= INIT_SEND;
      cur_byte_reg    <= PS2_RESET;
      retry_reg       <= '0;
      timer_reg       <= '0;
      led_latched_reg <= '0;
      led_pending_reg <= 1'b0;
      init_done_reg   <= 1'b0;
      error_reg       <= 1'b0;
      busy_reg        <= 1'b1;
      tx_req_reg      <= 1'b0;
      tx_data_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      cur_byte_reg    <= cur_byte_next;
      retry_reg       <= retry_next;
      timer_reg       <= timer_next;
      led_latched_reg <= led_latched_next;
      led_pending_reg <= led_pending_next;
      init_done_reg   <= init_done_next;
      error_reg       <= error_next;
      busy_reg        <= busy_next;
      tx_req_reg      <= tx_req_next;
      tx_data_reg     <= tx_data_next;
    end
  end

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (rx_data),
    .pop       (scan_pop),
    .head_data (scan_data),
    .empty     (fifo_empty),
    .full      (fifo_full_unused),
    .overflow  (overflow)
  );

  assign scan_valid = !fifo_empty;
  assign tx_req     = tx_req_reg;
  assign tx_data    = tx_data_reg;
  assign init_done  = init_done_reg;
  assign error      = error_reg;
  assign busy       = busy_reg;

endmodule

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

Command sequencer and receive buffer that sits between user logic and the `ps2_host` PHY. It initialises a PS/2 keyboard after reset with 0xFF, then waits for ACK and a BAT pass of 0xAA. It then serves LED update requests (0xED + mask), handling ACK/resend/timeout with bounded retries. All unsolicited device bytes (scan codes) go into a small FIFO for the consumer.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_000_000: max clk cycles spent in any wait state (20 ms at 50 MHz).
- `BAT_TIMEOUT_CYCLES`, default 50_000_000: wait for 0xAA after the reset ACK (1 s).
- `MAX_RETRY`, default 3: resend attempts per byte before error.
- `FIFO_DEPTH`, default 8: scan-code FIFO entries; power of two.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `tx_data`  out  8  byte to `ps2_host`.
- `tx_req`  out  1  one-cycle start pulse to `ps2_host`.
- `tx_ready`  in  1  `ps2_host` pulse: device ACKed line-level transmission.
- `rx_data`  in  8  received byte; valid when `rx_ready` is high.
- `rx_ready`  in  1  one-cycle byte strobe.
- `led_state`  in  3  {caps, num, scroll}; sampled on `led_update`.
- `led_update`  in  1  pulse: request LED write.
- `scan_data`  out  8  FIFO head.
- `scan_valid`  out  1  FIFO non-empty.
- `scan_pop`  in  1  consume head; ignored when empty.
- `init_done`  out  1  high once BAT passes; cleared only by reset.
- `busy`  out  1  command sequence in progress.
- `error`  out  1  sticky: retry/timeout exhaustion or BAT failure.
- `overflow`  out  1  sticky: byte dropped on full FIFO.

## Operation
- FSM states: `INIT_SEND`, `TX_WAIT`, `RESP_WAIT`, `BAT_WAIT`, `IDLE`, `LED_SEND`, `LED_DATA`, `ERR`.
- Reset enters `INIT_SEND` with `cur_byte`=0xFF and `retry`=0.
- Send step (any `*_SEND` / `LED_DATA`):
  - Drive `tx_data`=`cur_byte` and pulse `tx_req` for one cycle.
  - Go to `TX_WAIT`; `tx_req` stays low at least 1 cycle between pulses.
- `TX_WAIT`: on `tx_ready`, go to `RESP_WAIT`.
- `RESP_WAIT`, on `rx_ready`:
  - 0xFA: advance the sequence.
  - 0xFE: resend the same byte if `retry`<`MAX_RETRY` (retry++); otherwise `ERR`.
  - Any other byte: push it to the FIFO and keep waiting.
- Sequence advance:
  - After 0xFF: go to `BAT_WAIT`.
  - After 0xED: `LED_DATA` with byte {5'b0, led_latched}, where the latch is {caps,num,scroll} mapped to bits 2,1,0.
  - After the LED byte: `IDLE`.
  - `retry` clears on every advance.
- `BAT_WAIT`: 0xAA sets `init_done` and goes to `IDLE`. 0xFC, or `BAT_TIMEOUT_CYCLES` expiry, goes to `ERR`.
- Timeouts in `TX_WAIT`/`RESP_WAIT` count as a resend attempt, under the same retry rule.
- `IDLE`:
  - Every `rx_ready` byte is pushed to the FIFO.
  - `led_update` latches `led_state` and goes to `LED_SEND` (0xED).
- `led_update` while busy sets a pending flag with the latest `led_state`; it is serviced on return to `IDLE`.
- `ERR`: sets `error`. Behaves as `IDLE` for receive (bytes still pushed to the FIFO). LED requests are ignored. Exit only by reset.
- FIFO:
  - Push on full drops the byte and sets `overflow`.
  - Simultaneous push and pop when full: both succeed.
  - Pop when empty: no effect.

## Timing
- Reset values: `tx_req`=0, `tx_data`=0x00, `scan_valid`=0, `scan_data`=0x00, `init_done`=0, `busy`=1, `error`=0, `overflow`=0.
- `tx_req` goes high 1 cycle after entering a send state; `tx_data` is stable from that cycle until the next send.
- `rx_ready` to `scan_valid` (empty FIFO): 1 cycle. `scan_pop` to next head: 1 cycle.
- `busy`=0 only in `IDLE` or `ERR`. It is registered and rises the cycle after `led_update`.
- Timeout counter reloads on entry to every wait state. Expiry is at count 0, i.e. `TIMEOUT_CYCLES` cycles after entry.
- Reset mid-transfer: all state is cleared in one cycle and the full init sequence restarts.

## Structure
- Shared package `ps2_pkg`:
  - Command/response constants: `PS2_RESET`=0xFF, `PS2_SET_LED`=0xED, `PS2_ACK`=0xFA, `PS2_RESEND`=0xFE, `PS2_BAT_OK`=0xAA, `PS2_BAT_FAIL`=0xFC.
  - FSM state enum.
- Sub-module `ps2_rx_fifo`: synchronous FIFO with parameterised depth, first-word-fall-through, and full/empty/overflow flags.

## Test plan
- After reset, `tx_req` pulses with 0xFF. Drive `tx_ready`, then 0xFA, then 0xAA → `init_done`=1, `busy`=0.
- LED request: `led_state`=3'b101 with `led_update` → 0xED sent. After ACK, 0x05 is sent; after ACK, `busy`=0.
- Resend handling:
  - Reply 0xFE twice to 0xED → 0xED sent 3 times total, then completes.
  - A 4th 0xFE → `error`=1, and later `led_update` is ignored.
- Response silence: no response for `TIMEOUT_CYCLES` (TIMEOUT_CYCLES=100) → resend after exactly 100 cycles; after `MAX_RETRY` retries → `ERR`.
- Scan bytes in `IDLE`: push 9 bytes (0x1C…0x24) with no pop and depth 8 → first 8 are readable in order, `overflow`=1. A 0x1C arriving during `RESP_WAIT` is queued, not treated as ACK.
- Reset asserted while in `TX_WAIT` → outputs at reset values next cycle, and a new 0xFF `tx_req` pulse follows.
